// File: rtl/wb_stage_gen_pkg.sv
// Shared write-back stage definitions: payload field widths, CSR numbers,
// exception codes and the packed control-flag bundle carried by the stage.
package wb_stage_gen_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned VADDR_W   = 32;
    localparam int unsigned CSR_NUM_W = 14;
    localparam int unsigned ECODE_W   = 6;
    localparam int unsigned RETIRE_W  = 32;
    localparam int unsigned HOLD_W    = 4;

    localparam logic [CSR_NUM_W-1:0] CSR_ERA = 14'h6;

    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;

    // Per-instruction control flags held alongside the data payload.
    typedef struct packed {
        logic gr_we;
        logic csr_rd;
        logic csr_we;
        logic ertn;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_exc_encode.sv
// Priority exception encoder: lowest set exception bit selects the ecode.
// Ports: exc_i - exception vector (bit 0 highest priority)
//        ecode_o - encoded cause, ECODE_INT when no bit or an unmapped bit is set
module wb_exc_encode
    import wb_stage_gen_pkg::*;
#(
    parameter int unsigned NUM_EXC = 6
) (
    input  logic [NUM_EXC-1:0] exc_i,
    output logic [ECODE_W-1:0] ecode_o
);

    function automatic logic [ECODE_W-1:0] bit_ecode(input int idx);
        case (idx)
            0:       bit_ecode = ECODE_ADEF;
            1:       bit_ecode = ECODE_INE;
            2:       bit_ecode = ECODE_SYS;
            3:       bit_ecode = ECODE_BRK;
            4:       bit_ecode = ECODE_ALE;
            default: bit_ecode = ECODE_INT;
        endcase
    endfunction

    // Scan from the top down so the lowest set bit has the final word.
    always_comb begin
        ecode_o = ECODE_INT;
        for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
            if (exc_i[i]) begin
                ecode_o = bit_ecode(i);
            end
        end
    end

endmodule

// File: rtl/wb_stage_gen.sv
// Write-back stage: one-entry instruction register that commits register-file
// writes, CSR writes and exception/ertn flushes, then discards input for a
// programmable number of cycles after a flush.
// Ports: in_*        - upstream handshake and instruction payload
//        stall       - register-file port busy, blocks commit
//        csr_*       - CSR read/write port (csr_rvalue is the read data)
//        wb_*/ertn_flush - exception / return commit
//        rf_*        - register-file write and forwarding
//        retire_cnt  - committed non-excepting, non-ertn instructions
module wb_stage_gen
    import wb_stage_gen_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEST_W     = 5,
    parameter int unsigned NUM_EXC    = 6,
    parameter int unsigned FLUSH_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 in_gr_we,
    input  logic [DEST_W-1:0]    in_dest,
    input  logic [DATA_W-1:0]    in_result,
    input  logic                 in_csr_rd,
    input  logic                 in_csr_we,
    input  logic [CSR_NUM_W-1:0] in_csr_num,
    input  logic [DATA_W-1:0]    in_csr_wmask,
    input  logic [DATA_W-1:0]    in_csr_wvalue,
    input  logic                 in_ertn,
    input  logic [NUM_EXC-1:0]   in_exc,
    input  logic [VADDR_W-1:0]   in_vaddr,
    input  logic                 stall,
    output logic [CSR_NUM_W-1:0] csr_num,
    input  logic [DATA_W-1:0]    csr_rvalue,
    output logic                 csr_we,
    output logic [DATA_W-1:0]    csr_wmask,
    output logic [DATA_W-1:0]    csr_wvalue,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [PC_W-1:0]      wb_pc,
    output logic [VADDR_W-1:0]   wb_vaddr,
    output logic [ECODE_W-1:0]   wb_ecode,
    output logic                 rf_we,
    output logic [DEST_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [RETIRE_W-1:0]  retire_cnt
);

    logic                 valid_q,      valid_d;
    logic [PC_W-1:0]      pc_q,         pc_d;
    wb_ctrl_t             ctrl_q,       ctrl_d;
    logic [DEST_W-1:0]    dest_q,       dest_d;
    logic [DATA_W-1:0]    result_q,     result_d;
    logic [CSR_NUM_W-1:0] csr_num_q,    csr_num_d;
    logic [DATA_W-1:0]    csr_wmask_q,  csr_wmask_d;
    logic [DATA_W-1:0]    csr_wvalue_q, csr_wvalue_d;
    logic [NUM_EXC-1:0]   exc_q,        exc_d;
    logic [VADDR_W-1:0]   vaddr_q,      vaddr_d;
    logic [HOLD_W-1:0]    hold_q,       hold_d;
    logic [RETIRE_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic                 commit;
    logic                 exc_any;
    logic                 flush;
    logic                 holding;
    logic                 accept;
    logic [ECODE_W-1:0]   ecode_c;

    assign commit  = valid_q && !stall;
    assign exc_any = |exc_q;
    assign flush   = commit && (exc_any || ctrl_q.ertn);
    assign holding = (hold_q != '0);
    // While holding, input is drained and dropped; a flush commit also drops
    // whatever transfers alongside it.
    assign in_ready = holding || !valid_q || commit;
    assign accept   = in_valid && in_ready && !holding && !flush;

    wb_exc_encode #(
        .NUM_EXC (NUM_EXC)
    ) u_exc_encode (
        .exc_i   (exc_q),
        .ecode_o (ecode_c)
    );

    // Next-state for the instruction register, hold counter and retire counter.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        ctrl_d       = ctrl_q;
        dest_d       = dest_q;
        result_d     = result_q;
        csr_num_d    = csr_num_q;
        csr_wmask_d  = csr_wmask_q;
        csr_wvalue_d = csr_wvalue_q;
        exc_d        = exc_q;
        vaddr_d      = vaddr_q;
        hold_d       = hold_q;
        retire_cnt_d = retire_cnt_q;

        if (commit) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d       = 1'b1;
            pc_d          = in_pc;
            ctrl_d.gr_we  = in_gr_we;
            ctrl_d.csr_rd = in_csr_rd;
            ctrl_d.csr_we = in_csr_we;
            ctrl_d.ertn   = in_ertn;
            dest_d        = in_dest;
            result_d      = in_result;
            csr_num_d     = in_csr_num;
            csr_wmask_d   = in_csr_wmask;
            csr_wvalue_d  = in_csr_wvalue;
            exc_d         = in_exc;
            vaddr_d       = in_vaddr;
        end

        if (flush) begin
            hold_d = HOLD_W'(FLUSH_HOLD);
        end else if (holding) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        if (commit && !exc_any && !ctrl_q.ertn) begin
            retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            ctrl_q       <= '0;
            dest_q       <= '0;
            result_q     <= '0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            exc_q        <= '0;
            vaddr_q      <= '0;
            hold_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            ctrl_q       <= ctrl_d;
            dest_q       <= dest_d;
            result_q     <= result_d;
            csr_num_q    <= csr_num_d;
            csr_wmask_q  <= csr_wmask_d;
            csr_wvalue_q <= csr_wvalue_d;
            exc_q        <= exc_d;
            vaddr_q      <= vaddr_d;
            hold_q       <= hold_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Commit outputs; data fields read as zero whenever nothing commits.
    assign rf_we      = commit && ctrl_q.gr_we && !exc_any && !ctrl_q.ertn;
    assign rf_waddr   = commit ? dest_q : '0;
    assign rf_wdata   = !commit ? '0 : (ctrl_q.csr_rd ? csr_rvalue : result_q);
    assign wb_ex      = commit && exc_any;
    assign ertn_flush = commit && ctrl_q.ertn && !exc_any;
    assign wb_pc      = commit ? pc_q : '0;
    assign wb_vaddr   = commit ? vaddr_q : '0;
    assign wb_ecode   = commit ? ecode_c : '0;
    assign csr_we     = commit && ctrl_q.csr_we && !exc_any;
    assign csr_num    = wb_ex ? CSR_ERA : csr_num_q;
    assign csr_wmask  = commit ? csr_wmask_q : '0;
    assign csr_wvalue = commit ? csr_wvalue_q : '0;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_gen.sv
// Directed bench for wb_stage_gen: a scoreboard of expected commits checked
// by a negedge monitor, plus directed checks on handshake and counters.
module tb_wb_stage_gen;

    localparam int VW = 157;
    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        csr_rd;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic [5:0]  exc;
        logic [31:0] vaddr;
    } ins_t;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        in_csr_rd;
    logic        in_csr_we;
    logic [13:0] in_csr_num;
    logic [31:0] in_csr_wmask;
    logic [31:0] in_csr_wvalue;
    logic        in_ertn;
    logic [5:0]  in_exc;
    logic [31:0] in_vaddr;
    logic        stall;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    wb_stage_gen #(
        .DATA_W     (32),
        .DEST_W     (5),
        .NUM_EXC    (6),
        .FLUSH_HOLD (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_gr_we      (in_gr_we),
        .in_dest       (in_dest),
        .in_result     (in_result),
        .in_csr_rd     (in_csr_rd),
        .in_csr_we     (in_csr_we),
        .in_csr_num    (in_csr_num),
        .in_csr_wmask  (in_csr_wmask),
        .in_csr_wvalue (in_csr_wvalue),
        .in_ertn       (in_ertn),
        .in_exc        (in_exc),
        .in_vaddr      (in_vaddr),
        .stall         (stall),
        .csr_num       (csr_num),
        .csr_rvalue    (csr_rvalue),
        .csr_we        (csr_we),
        .csr_wmask     (csr_wmask),
        .csr_wvalue    (csr_wvalue),
        .wb_ex         (wb_ex),
        .ertn_flush    (ertn_flush),
        .wb_pc         (wb_pc),
        .wb_vaddr      (wb_vaddr),
        .wb_ecode      (wb_ecode),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire_cnt    (retire_cnt)
    );

    // Simple CSR file model: read data is a tag plus the addressed number.
    assign csr_rvalue = 32'hCAFE_0000 | 32'(csr_num);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_ecode(input logic [5:0] e);
        if (e[0])      return 6'h08;
        else if (e[1]) return 6'h0D;
        else if (e[2]) return 6'h0B;
        else if (e[3]) return 6'h0C;
        else if (e[4]) return 6'h09;
        else           return 6'h00;
    endfunction

    function automatic vec_t expect_of(input ins_t i);
        logic ea;
        ea = |i.exc;
        return {i.gr_we && !ea && !i.ertn, i.dest,
                i.csr_rd ? (32'hCAFE_0000 | 32'(i.csr_num)) : i.result,
                ea, i.ertn && !ea, ref_ecode(i.exc), i.csr_we && !ea,
                ea ? 14'h6 : i.csr_num, i.wvalue, i.pc, i.vaddr};
    endfunction

    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] dest,
                                input logic [31:0] result);
        ins_t i;
        i.pc = pc; i.gr_we = 1'b1; i.dest = dest; i.result = result;
        i.csr_rd = 1'b0; i.csr_we = 1'b0; i.csr_num = 14'h0;
        i.wmask = 32'h0; i.wvalue = 32'h0; i.ertn = 1'b0;
        i.exc = 6'h0; i.vaddr = 32'h0;
        return i;
    endfunction

    task automatic present(input ins_t i);
        in_valid = 1'b1;
        in_pc = i.pc; in_gr_we = i.gr_we; in_dest = i.dest; in_result = i.result;
        in_csr_rd = i.csr_rd; in_csr_we = i.csr_we; in_csr_num = i.csr_num;
        in_csr_wmask = i.wmask; in_csr_wvalue = i.wvalue;
        in_ertn = i.ertn; in_exc = i.exc; in_vaddr = i.vaddr;
    endtask

    task automatic push(input ins_t i);
        sb.push_back(expect_of(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every commit strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && (rf_we || wb_ex || ertn_flush || csr_we)) begin
            vec_t obs;
            vec_t exp;
            obs = {rf_we, rf_waddr, rf_wdata, wb_ex, ertn_flush, wb_ecode, csr_we,
                   csr_num, csr_wvalue, wb_pc, wb_vaddr};
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_unexpected observed %h expected none", obs);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                assert (obs === exp)
                else begin
                    errors++;
                    $error("FAIL sb_commit observed %h expected %h", obs, exp);
                end
            end
        end
    end

    initial begin
        ins_t a, b, c, d, e, f1, f2, f3, f4, g, h;

        resetn = 1'b0;
        stall  = 1'b0;
        present(mk(32'h0, 5'h0, 32'h0));
        in_valid = 1'b0;
        in_gr_we = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_wb_ex", 32'(wb_ex), 32'h0);
        chk("rst_ertn_flush", 32'(ertn_flush), 32'h0);
        chk("rst_csr_we", 32'(csr_we), 32'h0);
        chk("rst_retire", retire_cnt, 32'h0);
        step();
        resetn = 1'b1;
        step();

        // Back-to-back adds
        a = mk(32'h1c00_0000, 5'd1, 32'h11);
        b = mk(32'h1c00_0004, 5'd2, 32'h22);
        present(a); push(a);
        step();
        present(b); push(b);
        @(negedge clk);
        chk("b2b_first_we", 32'(rf_we), 32'h1);
        chk("b2b_first_addr", 32'(rf_waddr), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_we", 32'(rf_we), 32'h1);
        chk("b2b_second_addr", 32'(rf_waddr), 32'h2);
        step();
        @(negedge clk);
        chk("b2b_idle_we", 32'(rf_we), 32'h0);
        chk("b2b_retire", retire_cnt, 32'h2);

        // Stall for three cycles, then release
        c = mk(32'h1c00_0008, 5'd3, 32'h33);
        step();
        stall = 1'b1;
        present(c); push(c);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_rf_we", 32'(rf_we), 32'h0);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_wb_pc", wb_pc, 32'h0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release_we", 32'(rf_we), 32'h1);
        step();
        @(negedge clk);
        chk("stall_single_commit", 32'(rf_we), 32'h0);
        chk("stall_retire", retire_cnt, 32'h3);

        // Exception with SYS and ALE set
        d = mk(32'h1c00_000c, 5'd4, 32'h44);
        d.exc = 6'b010100; d.csr_we = 1'b1; d.csr_num = 14'h40;
        d.wvalue = 32'h55; d.vaddr = 32'hDEAD_BEE0;
        step();
        present(d); push(d);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("exc_wb_ex", 32'(wb_ex), 32'h1);
        chk("exc_ecode", 32'(wb_ecode), 32'h0B);
        chk("exc_rf_we", 32'(rf_we), 32'h0);
        chk("exc_csr_num", 32'(csr_num), 32'h6);
        chk("exc_csr_we", 32'(csr_we), 32'h0);
        step();
        @(negedge clk);
        chk("exc_retire", retire_cnt, 32'h3);
        chk("exc_hold_ready", 32'(in_ready), 32'h1);
        step();
        step();

        // ertn flush with in_valid held high
        e  = mk(32'h1c00_0010, 5'd5, 32'h55); e.ertn = 1'b1;
        f1 = mk(32'h1c00_0014, 5'd6, 32'h66);
        f2 = mk(32'h1c00_0018, 5'd7, 32'h77);
        f3 = mk(32'h1c00_001c, 5'd8, 32'h88);
        f4 = mk(32'h1c00_0020, 5'd9, 32'h99);
        present(e); push(e);
        step();
        present(f1);
        @(negedge clk);
        chk("ertn_flush", 32'(ertn_flush), 32'h1);
        chk("ertn_rf_we", 32'(rf_we), 32'h0);
        step();
        present(f2);
        @(negedge clk);
        chk("hold2_ready", 32'(in_ready), 32'h1);
        chk("hold2_rf_we", 32'(rf_we), 32'h0);
        step();
        present(f3);
        @(negedge clk);
        chk("hold1_ready", 32'(in_ready), 32'h1);
        chk("hold1_rf_we", 32'(rf_we), 32'h0);
        step();
        present(f4); push(f4);
        @(negedge clk);
        chk("hold0_ready", 32'(in_ready), 32'h1);
        chk("hold0_rf_we", 32'(rf_we), 32'h0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_hold_we", 32'(rf_we), 32'h1);
        chk("post_hold_addr", 32'(rf_waddr), 32'h9);
        step();
        @(negedge clk);
        chk("ertn_retire", retire_cnt, 32'h4);

        // Retire counter wrap, with a CSR read/write instruction
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        step();
        chk("wrap_preset", retire_cnt, 32'hFFFF_FFFF);
        g = mk(32'h1c00_0024, 5'd10, 32'h0);
        g.csr_rd = 1'b1; g.csr_we = 1'b1; g.csr_num = 14'h5;
        g.wmask = 32'hFFFF_FFFF; g.wvalue = 32'h1234_5678;
        present(g); push(g);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("csr_we", 32'(csr_we), 32'h1);
        chk("csr_rd_wdata", rf_wdata, 32'hCAFE_0005);
        chk("csr_wmask", csr_wmask, 32'hFFFF_FFFF);
        step();
        @(negedge clk);
        chk("wrap_retire", retire_cnt, 32'h0);

        // Reset while an instruction is held under stall
        h = mk(32'h1c00_0028, 5'd11, 32'h77); h.csr_we = 1'b1;
        step();
        stall = 1'b1;
        present(h);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_held", 32'(in_ready), 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'h1);
        chk("rst_mid_rf_we", 32'(rf_we), 32'h0);
        chk("rst_mid_csr_we", 32'(csr_we), 32'h0);
        chk("rst_mid_wb_pc", wb_pc, 32'h0);
        chk("rst_mid_csr_num", 32'(csr_num), 32'h0);
        chk("rst_mid_retire", retire_cnt, 32'h0);
        stall = 1'b0;
        step();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_drop_rf_we", 32'(rf_we), 32'h0);
            chk("rst_drop_csr_we", 32'(csr_we), 32'h0);
        end

        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
